psram_arbiter: RTL and testbench
================================

// Module: psram_arbiter
// PURPOSE
//  Two-requester round-robin arbiter and sequencer in front of the psram top module.
//  Serialises 16-bit word read/write requests, drives address/read_write/quad_start/data_in,
//  waits for endcommand, returns read data and enforces an inter-command CE-high gap.
//  Grants nothing until psram reports qpi_on (init sequence complete). Sits between UART/user logic and psram.
// PARAMETERS
//  GAP_CYC      4     idle cycles after each transaction before next quad_start (>=1)
//  TIMEOUT_CYC  64    max cycles in BUSY waiting for endcommand before abort (>=24)
// PORTS
//  mem_clk      in   1   system/PSRAM clock, all logic on posedge
//  rst_n        in   1   synchronous active-low reset
//  qpi_on       in   1   from psram: init done, QPI mode active
//  r0_req       in   1   requester 0 request (level, held until r0_ack)
//  r0_we        in   1   requester 0: 1=write, 0=read
//  r0_addr      in   23  requester 0 word address
//  r0_wdata     in   16  requester 0 write data
//  r0_ack       out  1   1-cycle pulse: requester 0 transaction complete
//  r1_req/r1_we/r1_addr/r1_wdata/r1_ack  same as r0_*, requester 1
//  rd_data      out  16  read data, valid in ack cycle of a read, held until next read ack
//  err          out  1   1-cycle pulse coincident with ack when transaction timed out
//  busy         out  1   high in START/BUSY/GAP
//  address      out  23  to psram
//  read_write   out  2   to psram: 2'b10 read, 2'b01 write, 2'b00 idle
//  quad_start   out  1   to psram: 1-cycle start pulse
//  data_in      out  16  to psram write data
//  endcommand   in   1   from psram: transaction finished
//  data_out     in   16  from psram read data
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, all outputs 0, read_write=2'b00, last_grant=1 (r0 wins first tie),
//   gap/timeout counters 0. Reset mid-transaction aborts immediately; no ack issued.
//  States: IDLE -> START -> BUSY -> GAP -> IDLE.
//  IDLE: if qpi_on && (r0_req||r1_req): grant; latch addr/we/wdata of winner into address/read_write/data_in;
//   quad_start<=1; -> START. qpi_on=0: no grant, requests wait. endcommand in IDLE ignored.
//  Arbitration: single requester wins; both -> requester != last_grant; last_grant updated at grant.
//  START (1 cycle): quad_start<=0; timeout counter cleared; -> BUSY.
//  BUSY: address/read_write/data_in held stable. On endcommand=1: pulse rX_ack of granted requester;
//   if read, rd_data<=data_out same edge; read_write<=2'b00; -> GAP.
//   Timeout counter increments each BUSY cycle; on reaching TIMEOUT_CYC-1 without endcommand:
//   ack + err pulse, rd_data unchanged, read_write<=2'b00, -> GAP.
//  GAP: counts GAP_CYC cycles, then -> IDLE. Requests arriving during GAP queued (level held).
//  Latency: req seen in IDLE at edge N -> quad_start high N+1, BUSY from N+2; ack at edge after endcommand.
//  Requester must keep req and fields stable until ack; req dropped before grant is simply not served.
//  Requester deasserts req in ack cycle; a req still high the cycle after ack is a new request.
//  Exactly one ack per grant; never both acks in one cycle; no ack without prior grant.
//  Address passes unmodified (no wrap/increment); 23-bit range fully usable.
// TESTING
//  1 Reset, qpi_on=0, r0_req=1 -> quad_start never pulses; raise qpi_on -> quad_start pulse next cycle.
//  2 r0 write addr=23'h000010 data=16'hA5C3 -> read_write=2'b01, data_in=A5C3 in BUSY, r0_ack one pulse, err=0.
//  3 r1 read addr=23'h000010, model returns 16'hA5C3 -> rd_data=A5C3 in r1_ack cycle, read_write=2'b10 in BUSY.
//  4 r0,r1 both held high for 4 transactions -> grants alternate r0,r1,r0,r1; GAP_CYC idle cycles between.
//  5 endcommand held 0 -> ack+err pulse exactly TIMEOUT_CYC cycles into BUSY; next request served normally.
//  6 rst_n low in mid-BUSY -> next cycle all outputs 0, no ack; post-reset request completes normally.

Source files
------------

// File: rtl/psram_arbiter.sv
// ---------------------------------------------------------------------------
// psram_arbiter
// Two-requester round-robin arbiter and command sequencer placed in front of
// the psram controller. It serialises 16-bit word read/write requests, drives
// address/read_write/quad_start/data_in, waits for endcommand (or gives up
// after TIMEOUT_CYC cycles), returns read data and holds a CE-high gap of
// GAP_CYC cycles between commands. Nothing is granted until psram reports
// qpi_on.
//
// Ports
//   mem_clk, rst_n        clock (posedge) and synchronous active-low reset
//   qpi_on                psram init done
//   rX_req/we/addr/wdata  requester X command (level request, held to ack)
//   rX_ack                one-cycle completion pulse for requester X
//   rd_data               read data, updated on a successful read ack
//   err                   one-cycle pulse alongside ack on timeout
//   busy                  high while a command or its gap is in progress
//   address/read_write/quad_start/data_in   command to psram
//   endcommand/data_out   completion and read data from psram
// ---------------------------------------------------------------------------
module psram_arbiter #(
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        mem_clk,
    input  logic        rst_n,
    input  logic        qpi_on,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [22:0] r0_addr,
    input  logic [15:0] r0_wdata,
    output logic        r0_ack,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [22:0] r1_addr,
    input  logic [15:0] r1_wdata,
    output logic        r1_ack,
    output logic [15:0] rd_data,
    output logic        err,
    output logic        busy,
    output logic [22:0] address,
    output logic [1:0]  read_write,
    output logic        quad_start,
    output logic [15:0] data_in,
    input  logic        endcommand,
    input  logic [15:0] data_out
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_q, grant_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [22:0]   address_q, address_d;
    logic [1:0]    read_write_q, read_write_d;
    logic [15:0]   data_in_q, data_in_d;
    logic          quad_start_q, quad_start_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          r0_ack_q, r0_ack_d;
    logic          r1_ack_q, r1_ack_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          grant_sel;
    logic          sel_we;

    // Next-state and next-output computation for the command sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        address_d    = address_q;
        read_write_d = read_write_q;
        data_in_d    = data_in_q;
        quad_start_d = 1'b0;
        rd_data_d    = rd_data_q;
        r0_ack_d     = 1'b0;
        r1_ack_d     = 1'b0;
        err_d        = 1'b0;
        grant_sel    = 1'b0;
        sel_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (qpi_on && (r0_req || r1_req)) begin
                    // On a tie the requester that did not win last time goes.
                    if (r0_req && r1_req) begin
                        grant_sel = ~last_grant_q;
                    end else begin
                        grant_sel = r1_req;
                    end
                    sel_we       = grant_sel ? r1_we : r0_we;
                    grant_d      = grant_sel;
                    last_grant_d = grant_sel;
                    address_d    = grant_sel ? r1_addr : r0_addr;
                    data_in_d    = grant_sel ? r1_wdata : r0_wdata;
                    read_write_d = sel_we ? 2'b01 : 2'b10;
                    quad_start_d = 1'b1;
                    state_d      = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                tmo_d   = {TW{1'b0}};
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (endcommand) begin
                    r0_ack_d = ~grant_q;
                    r1_ack_d = grant_q;
                    if (read_write_q == 2'b10) begin
                        rd_data_d = data_out;
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                    read_write_d = 2'b00;
                    gap_d        = {GW{1'b0}};
                    state_d      = S_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    // Abort: still acknowledge so the requester is released.
                    r0_ack_d     = ~grant_q;
                    r1_ack_d     = grant_q;
                    err_d        = 1'b1;
                    read_write_d = 2'b00;
                    gap_d        = {GW{1'b0}};
                    state_d      = S_GAP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            tmo_q        <= {TW{1'b0}};
            gap_q        <= {GW{1'b0}};
            address_q    <= 23'd0;
            read_write_q <= 2'b00;
            data_in_q    <= 16'd0;
            quad_start_q <= 1'b0;
            rd_data_q    <= 16'd0;
            r0_ack_q     <= 1'b0;
            r1_ack_q     <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            address_q    <= address_d;
            read_write_q <= read_write_d;
            data_in_q    <= data_in_d;
            quad_start_q <= quad_start_d;
            rd_data_q    <= rd_data_d;
            r0_ack_q     <= r0_ack_d;
            r1_ack_q     <= r1_ack_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign address    = address_q;
    assign read_write = read_write_q;
    assign data_in    = data_in_q;
    assign quad_start = quad_start_q;
    assign rd_data    = rd_data_q;
    assign r0_ack     = r0_ack_q;
    assign r1_ack     = r1_ack_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_psram_arbiter
// Randomised self-checking bench for psram_arbiter. A transaction-level model
// (pending-request flags, round-robin rule, cycle counts since grant/ack and a
// scoreboard memory) predicts every output each cycle; a small psram model
// answers commands with a chosen latency or never answers (timeout).
// ---------------------------------------------------------------------------
module tb_psram_arbiter;

    localparam int GAP_CYC     = 4;
    localparam int TIMEOUT_CYC = 64;

    logic        mem_clk = 1'b0;
    logic        rst_n, qpi_on;
    logic        r0_req, r0_we, r0_ack, r1_req, r1_we, r1_ack;
    logic [22:0] r0_addr, r1_addr, address;
    logic [15:0] r0_wdata, r1_wdata, rd_data, data_in, data_out;
    logic        err, busy, quad_start, endcommand;
    logic [1:0]  read_write;

    always #5 mem_clk = ~mem_clk;

    psram_arbiter #(.GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .mem_clk(mem_clk), .rst_n(rst_n), .qpi_on(qpi_on),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ack(r1_ack),
        .rd_data(rd_data), .err(err), .busy(busy),
        .address(address), .read_write(read_write), .quad_start(quad_start), .data_in(data_in),
        .endcommand(endcommand), .data_out(data_out)
    );

    int total = 0;
    int bad   = 0;

    // Requester side of the model
    bit          pend [2];
    bit          p_we [2];
    logic [22:0] p_addr [2];
    logic [15:0] p_wdata [2];

    // Transaction model
    bit          active, to_mode, model_last, idle_pend;
    int          bc, ack_bc, lat, win, since_ack;
    logic [15:0] model_rd;
    logic [15:0] sb_mem [logic [22:0]];

    // psram model
    logic [15:0] ps_mem [logic [22:0]];
    logic [22:0] ps_addr;
    logic [1:0]  ps_rw;
    logic [15:0] ps_data;

    // Directed-test knobs
    bit drv_rst_n, drv_qpi, rand_en, force_to, rec_en;
    int force_lat, rst_at_bc, refill;
    int gq[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [22:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [22:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return 23'h000010;
            1: return 23'h000011;
            2: return 23'h400000;
            3: return 23'h123456;
            4: return 23'h7FFFFF;
            default: return 23'($urandom);
        endcase
    endfunction

    task automatic new_req(input int i, input bit we, input logic [22:0] a, input logic [15:0] d);
        pend[i] = 1'b1; p_we[i] = we; p_addr[i] = a; p_wdata[i] = d;
    endtask

    task automatic apply_reqs();
        r0_req = pend[0]; r0_we = p_we[0]; r0_addr = p_addr[0]; r0_wdata = p_wdata[0];
        r1_req = pend[1]; r1_we = p_we[1]; r1_addr = p_addr[1]; r1_wdata = p_wdata[1];
    endtask

    // One clock: check outputs against the model, then drive the next inputs.
    task automatic step();
        bit exp_ack;
        @(negedge mem_clk);
        if (!rst_n) begin
            check_eq("rst_quad_start", 32'(quad_start), 32'd0);
            check_eq("rst_read_write", 32'(read_write), 32'd0);
            check_eq("rst_address", 32'(address), 32'd0);
            check_eq("rst_data_in", 32'(data_in), 32'd0);
            check_eq("rst_rd_data", 32'(rd_data), 32'd0);
            check_eq("rst_acks", 32'({r0_ack, r1_ack, err, busy}), 32'd0);
            active = 1'b0; since_ack = 1000; model_last = 1'b1; model_rd = 16'd0;
        end else begin
            if (since_ack < 1000) since_ack++;
            if (active) bc++;
            check_eq("quad_start", 32'(quad_start), 32'(idle_pend));
            if (idle_pend) begin
                win = (pend[0] && pend[1]) ? (model_last ? 0 : 1) : (pend[1] ? 1 : 0);
                model_last = win[0];
                active = 1'b1; bc = 0;
                to_mode = force_to || (rand_en && $urandom_range(0, 9) == 0);
                lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 12));
                ack_bc = to_mode ? TIMEOUT_CYC + 1 : lat + 1;
                if (rec_en) gq.push_back(win);
                check_eq("grant_addr", 32'(address), 32'(p_addr[win]));
                check_eq("grant_rw", 32'(read_write), p_we[win] ? 32'd1 : 32'd2);
                check_eq("grant_wdata", 32'(data_in), 32'(p_wdata[win]));
                ps_addr = address; ps_rw = read_write; ps_data = data_in;
            end
            if (active && bc == 1) begin
                check_eq("busy_rw", 32'(read_write), p_we[win] ? 32'd1 : 32'd2);
                check_eq("busy_addr", 32'(address), 32'(p_addr[win]));
            end
            exp_ack = active && (bc == ack_bc);
            check_eq("r0_ack", 32'(r0_ack), 32'(exp_ack && win == 0));
            check_eq("r1_ack", 32'(r1_ack), 32'(exp_ack && win == 1));
            check_eq("err", 32'(err), 32'(exp_ack && to_mode));
            if (exp_ack) begin
                if (!to_mode) begin
                    if (p_we[win]) sb_mem[p_addr[win]] = p_wdata[win];
                    else model_rd = sb_mem.exists(p_addr[win]) ? sb_mem[p_addr[win]] : init_val(p_addr[win]);
                end
                check_eq("ack_rw_idle", 32'(read_write), 32'd0);
                pend[win] = 1'b0; active = 1'b0; since_ack = 0;
            end
            check_eq("rd_data", 32'(rd_data), 32'(model_rd));
            check_eq("busy", 32'(busy), 32'(active || since_ack < GAP_CYC));
        end

        // psram model: answer after lat BUSY cycles unless this is a timeout case
        endcommand = 1'b0;
        data_out   = 16'($urandom);
        if (rst_n && active && !to_mode && bc == lat) begin
            endcommand = 1'b1;
            if (ps_rw == 2'b01) ps_mem[ps_addr] = ps_data;
            if (ps_rw == 2'b10) data_out = ps_mem.exists(ps_addr) ? ps_mem[ps_addr] : init_val(ps_addr);
        end

        if (active && bc == rst_at_bc) begin
            drv_rst_n = 1'b0; rst_at_bc = -1;
        end
        rst_n  = drv_rst_n;
        qpi_on = drv_qpi;

        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && refill > 0) begin
                new_req(i, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
                refill--;
            end else if (!pend[i] && rand_en && $urandom_range(0, 3) == 0) begin
                new_req(i, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
            end
        end
        apply_reqs();
        idle_pend = rst_n && qpi_on && !active && since_ack >= GAP_CYC && (pend[0] || pend[1]);
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            step();
            done = !active && !pend[0] && !pend[1] && refill == 0 && since_ack >= GAP_CYC;
        end
        check_eq("drain", 32'(done), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; qpi_on = 1'b0; endcommand = 1'b0; data_out = 16'd0;
        drv_rst_n = 1'b0; drv_qpi = 1'b0; rand_en = 1'b0; force_to = 1'b0; rec_en = 1'b0;
        force_lat = -1; rst_at_bc = -1; refill = 0;
        pend[0] = 1'b0; pend[1] = 1'b0; p_we[0] = 1'b0; p_we[1] = 1'b0;
        p_addr[0] = 23'd0; p_addr[1] = 23'd0; p_wdata[0] = 16'd0; p_wdata[1] = 16'd0;
        active = 1'b0; to_mode = 1'b0; model_last = 1'b1; idle_pend = 1'b0;
        bc = 0; ack_bc = 0; lat = 1; win = 0; since_ack = 1000; model_rd = 16'd0;
        ps_addr = 23'd0; ps_rw = 2'b00; ps_data = 16'd0;
        apply_reqs();

        // Reset state
        repeat (3) step();
        drv_rst_n = 1'b1;

        // qpi_on low blocks grants; r0 write 0x10 = A5C3 once qpi_on rises
        new_req(0, 1'b1, 23'h000010, 16'hA5C3);
        repeat (10) step();
        drv_qpi = 1'b1;
        wait_done();

        // r1 reads it back
        new_req(1, 1'b0, 23'h000010, 16'h1234);
        wait_done();
        check_eq("t3_rd_data", 32'(rd_data), 32'h0000A5C3);

        // Both held for four transactions: strict alternation
        gq.delete();
        rec_en = 1'b1;
        new_req(0, 1'b1, 23'h000020, 16'h1111);
        new_req(1, 1'b1, 23'h000021, 16'h2222);
        refill = 2;
        wait_done();
        rec_en = 1'b0;
        check_eq("rr_count", 32'(gq.size()), 32'd4);
        for (int k = 0; k < gq.size(); k++) check_eq("rr_order", 32'(gq[k]), 32'(k % 2));

        // Timeout on a read of the top address, then a normal write/read there
        force_to = 1'b1;
        new_req(0, 1'b0, 23'h7FFFFF, 16'h0000);
        wait_done();
        force_to = 1'b0;
        new_req(1, 1'b1, 23'h7FFFFF, 16'hC0DE);
        wait_done();
        new_req(0, 1'b0, 23'h7FFFFF, 16'h0000);
        wait_done();
        check_eq("top_rd_data", 32'(rd_data), 32'h0000C0DE);

        // Reset in mid-BUSY aborts; the held request is then served
        force_lat = 10; rst_at_bc = 3;
        new_req(0, 1'b1, 23'h2AAAAA, 16'hBEEF);
        for (int k = 0; k < 100 && rst_n; k++) step();
        check_eq("rst_injected", 32'(rst_n), 32'd0);
        step(); step();
        drv_rst_n = 1'b1; force_lat = -1;
        wait_done();
        new_req(1, 1'b0, 23'h2AAAAA, 16'h0000);
        wait_done();
        check_eq("post_rst_rd", 32'(rd_data), 32'h0000BEEF);

        // Random traffic
        rand_en = 1'b1;
        repeat (3000) step();
        rand_en = 1'b0;
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
